wb_intgen_multi: RTL and testbench

WB_INTGEN_MULTI -- requirements
Module: wb_intgen_multi

---
 rtl/wb_intgen_multi_pkg.sv | 17 +
 rtl/wb_intgen_multi_if.sv | 25 ++
 rtl/wb_intgen_multi_chan.sv | 43 ++++
 rtl/wb_intgen_multi.sv | 169 ++++++++++++++++
 tb/tb_wb_intgen_multi.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_intgen_multi_pkg.sv
// Shared constants for the multi-channel Wishbone interrupt generator:
// register offsets, MODE bit encoding and the channel-count ceiling.
package wb_intgen_multi_pkg;

   localparam int MAX_CH = 16;

   localparam logic [7:0] OFF_PENDING  = 8'h00;
   localparam logic [7:0] OFF_ENABLE   = 8'h04;
   localparam logic [7:0] OFF_FORCE    = 8'h08;
   localparam logic [7:0] OFF_MODE     = 8'h0C;
   localparam logic [7:0] OFF_PRESCALE = 8'h10;
   localparam logic [7:0] OFF_COUNT    = 8'h20;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/wb_intgen_multi_if.sv
// Wishbone classic slave bundle for wb_intgen_multi; clock and reset
// stay outside as plain ports.
interface wb_intgen_multi_if;
   import wb_intgen_multi_pkg::*;

   logic [7:0]  wb_adr_i;
   logic [31:0] wb_dat_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        wb_err_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
      input  wb_dat_o, wb_ack_o, wb_err_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
      output wb_dat_o, wb_ack_o, wb_err_o
   );

endinterface

// File: rtl/wb_intgen_multi_chan.sv
// One countdown channel: reload register, live counter and the
// expiry pulse that feeds the PENDING register.
module wb_intgen_multi_chan
   import wb_intgen_multi_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             periodic,
   output logic [CNT_W-1:0] count,
   output logic             expire
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] reload_q;
   logic [CNT_W-1:0] wrap_val;
   logic             at_one;

   assign at_one   = cnt_q == ONE;
   // a bus load on the expiry edge swallows that expiry
   assign expire   = tick & at_one & ~load;
   assign wrap_val = (periodic && reload_q != '0) ? reload_q : '0;
   assign count    = cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         reload_q <= '0;
      end else if (load) begin
         cnt_q    <= load_val;
         reload_q <= load_val;
      end else if (tick && cnt_q != '0) begin
         cnt_q <= at_one ? wrap_val : cnt_q - ONE;
      end
   end

endmodule

// File: rtl/wb_intgen_multi.sv
// Wishbone multi-channel countdown interrupt generator.
// Optional count prescaler: define WB_INTGEN_MULTI_PRESCALER_EN.
module wb_intgen_multi
   import wb_intgen_multi_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   wb_intgen_multi_if.slave  bus,
   output logic [NUM_CH-1:0] irq_o,
   output logic              irq_any_o
);

   if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_cfg
      $error("wb_intgen_multi: NUM_CH out of range");
   end

   logic [7:0]        addr;
   logic [31:0]       wdat;
   logic              req;
   logic              wr;
   logic              hit;
   logic              sel_pend;
   logic              sel_en;
   logic              sel_force;
   logic              sel_mode;
   logic              sel_pre;
   logic              pre_hit;
   logic [NUM_CH-1:0] cnt_sel;
   logic [NUM_CH-1:0] load;
   logic [NUM_CH-1:0] expire;
   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] enable;
   logic [NUM_CH-1:0] mode;
   logic [NUM_CH-1:0] w1c;
   logic [NUM_CH-1:0] frc;
   logic [CNT_W-1:0]  cnt [NUM_CH];
   logic [CNT_W-1:0]  cnt_rd;
   logic [31:0]       pre_rd;
   logic [31:0]       rdata;
   logic              tick;
   logic              ack_q;
   logic              err_q;
   logic [31:0]       dat_q;
   logic              unused_ok;

   assign addr = {bus.wb_adr_i[7:2], 2'b00};
   assign wdat = bus.wb_dat_i;
   // the response flag blocks a held strobe until its cycle has passed
   assign req  = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q & ~err_q;
   assign wr   = req & bus.wb_we_i;

   assign sel_pend  = addr == OFF_PENDING;
   assign sel_en    = addr == OFF_ENABLE;
   assign sel_force = addr == OFF_FORCE;
   assign sel_mode  = addr == OFF_MODE;
   assign sel_pre   = addr == OFF_PRESCALE;

   always_comb begin
      cnt_sel = '0;
      cnt_rd  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (addr == OFF_COUNT + 8'(4 * i)) begin
            cnt_sel[i] = 1'b1;
            cnt_rd     = cnt[i];
         end
      end
   end

   assign hit = sel_pend | sel_en | sel_force | sel_mode
              | pre_hit | (|cnt_sel);

   always_comb begin
      rdata = '0;
      unique case (1'b1)
         sel_pend: rdata = 32'(pending);
         sel_en:   rdata = 32'(enable);
         sel_mode: rdata = 32'(mode);
         pre_hit:  rdata = pre_rd;
         |cnt_sel: rdata = 32'(cnt_rd);
         default:  rdata = '0;
      endcase
   end

   assign w1c  = (wr && sel_pend)  ? wdat[NUM_CH-1:0] : '0;
   assign frc  = (wr && sel_force) ? wdat[NUM_CH-1:0] : '0;
   assign load = {NUM_CH{wr}} & cnt_sel;

`ifdef WB_INTGEN_MULTI_PRESCALER_EN
   logic [15:0] prescale;
   logic [15:0] div;

   assign pre_hit = sel_pre;
   assign pre_rd  = 32'(prescale);
   assign tick    = div == prescale;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         prescale <= '0;
         div      <= '0;
      end else if (wr && sel_pre) begin
         prescale <= wdat[15:0];
         div      <= '0;
      end else begin
         div <= tick ? '0 : div + 16'd1;
      end
   end
`else
   assign pre_hit = 1'b0;
   assign pre_rd  = '0;
   assign tick    = 1'b1;
`endif

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      wb_intgen_multi_chan #(
         .CNT_W(CNT_W)
      ) u_chan (
         .clk      (wb_clk_i),
         .rst      (wb_rst_i),
         .tick     (tick),
         .load     (load[g]),
         .load_val (wdat[CNT_W-1:0]),
         .periodic (mode[g] == MODE_PERIODIC),
         .count    (cnt[g]),
         .expire   (expire[g])
      );
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         pending <= '0;
         enable  <= '0;
         mode    <= {NUM_CH{MODE_ONESHOT}};
      end else begin
         // hardware sets are ORed after the clear so they win
         pending <= (pending & ~w1c) | frc | expire;
         if (wr && sel_en) begin
            enable <= wdat[NUM_CH-1:0];
         end
         if (wr && sel_mode) begin
            mode <= wdat[NUM_CH-1:0];
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         dat_q <= '0;
      end else begin
         ack_q <= req & hit;
         err_q <= req & ~hit;
         dat_q <= (req && hit && !bus.wb_we_i) ? rdata : '0;
      end
   end

   assign bus.wb_ack_o = ack_q;
   assign bus.wb_err_o = err_q;
   assign bus.wb_dat_o = dat_q;

   assign irq_o     = pending & enable;
   assign irq_any_o = |irq_o;

   assign unused_ok = ^{bus.wb_adr_i[1:0], wdat, sel_pre};

endmodule

// File: tb/tb_wb_intgen_multi.sv
// Directed self-checking bench for wb_intgen_multi (NUM_CH=4, CNT_W=16).
// Prescaler checks run only when WB_INTGEN_MULTI_PRESCALER_EN is defined.
module tb_wb_intgen_multi;
   import wb_intgen_multi_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] irq;
   logic       irq_any;

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;
   int last_edge = 0;

   wb_intgen_multi_if bus ();

   wb_intgen_multi #(
      .NUM_CH (4),
      .CNT_W  (16)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .bus       (bus),
      .irq_o     (irq),
      .irq_any_o (irq_any)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // drive at a negedge, return at the negedge after the response edge
   task automatic xfer(input logic we, input logic [7:0] a,
                       input logic [31:0] d, output logic [31:0] rd,
                       output logic [1:0] resp);
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      bus.wb_we_i  = we;
      bus.wb_adr_i = a;
      bus.wb_dat_i = d;
      rd   = '0;
      resp = 2'b00;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (bus.wb_ack_o || bus.wb_err_o) begin
            resp = {bus.wb_ack_o, bus.wb_err_o};
            rd   = bus.wb_dat_o;
            break;
         end
      end
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      last_edge    = cyc_n;
      if (resp == 2'b00) chk("bus_timeout", 1'b0, 1'b1);
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d,
                     input string tag);
      logic [31:0] rd;
      logic [1:0]  resp;
      xfer(1'b1, a, d, rd, resp);
      chk({tag, "_resp"}, 32'(resp), 32'h2);
   endtask

   task automatic rd(input logic [7:0] a, input logic [31:0] exp,
                     input string tag);
      logic [31:0] v;
      logic [1:0]  resp;
      xfer(1'b0, a, 32'h0, v, resp);
      chk({tag, "_resp"}, 32'(resp), 32'h2);
      chk(tag, v, exp);
   endtask

   task automatic wait_irq(input int ch, output int e);
      e = -1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (irq[ch]) begin
            e = cyc_n;
            break;
         end
      end
   endtask

   function automatic logic [7:0] cnt_adr(input int ch);
      return OFF_COUNT + 8'(4 * ch);
   endfunction

   initial begin
      logic [31:0] v;
      logic [1:0]  resp;
      int          w;
      int          e1;
      int          e2;
      int          e3;
      logic        seen;

      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      bus.wb_adr_i = '0;
      bus.wb_dat_i = '0;

      repeat (3) @(negedge clk);
      chk("rst_resp", 32'({bus.wb_ack_o, bus.wb_err_o}), 32'h0);
      chk("rst_dat", bus.wb_dat_o, 32'h0);
      chk("rst_irq", 32'({irq_any, irq}), 32'h0);
      rst = 1'b0;

      // reset readback, single-cycle ack
      rd(OFF_PENDING, 32'h0, "r_pend");
      @(negedge clk);
      chk("single_ack", 32'({bus.wb_ack_o, bus.wb_err_o}), 32'h0);
      rd(OFF_ENABLE, 32'h0, "r_en");
      rd(OFF_MODE, 32'h0, "r_mode");
      rd(cnt_adr(0), 32'h0, "r_cnt0");
      chk("r_irq", 32'(irq), 32'h0);

      // one-shot channel 0
      wr(OFF_ENABLE, 32'h1, "en1");
      wr(OFF_MODE, 32'h0, "mode0");
      wr(cnt_adr(0), 32'd5, "cnt0_5");
      w = last_edge;
      wait_irq(0, e1);
      chk("os_edge", e1, w + 5);
      chk("os_any", 32'(irq_any), 32'h1);
      rd(cnt_adr(0), 32'h0, "os_cnt_hold");
      rd(OFF_PENDING, 32'h1, "os_pend");
      wr(OFF_ENABLE, 32'h0, "mask");
      chk("mask_irq", 32'(irq), 32'h0);
      rd(OFF_PENDING, 32'h1, "mask_keeps_pend");
      wr(OFF_PENDING, 32'h1, "w1c0");
      rd(OFF_PENDING, 32'h0, "w1c0_done");

      // periodic channel 1, period 3
      wr(OFF_MODE, 32'h2, "mode2");
      wr(OFF_ENABLE, 32'h2, "en2");
      wr(cnt_adr(1), 32'd3, "cnt1_3");
      w = last_edge;
      wait_irq(1, e1);
      chk("per_e1", e1, w + 3);
      wr(OFF_PENDING, 32'h2, "per_clr1");
      chk("per_clr_irq", 32'(irq[1]), 32'h0);
      wait_irq(1, e2);
      chk("per_e2", e2, e1 + 3);
      wr(OFF_PENDING, 32'h2, "per_clr2");
      wait_irq(1, e3);
      chk("per_e3", e3, e2 + 3);
      wr(cnt_adr(1), 32'h0, "cnt1_stop");
      wr(OFF_PENDING, 32'h2, "per_clr3");
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         seen |= irq[1];
      end
      chk("per_stopped", 32'(seen), 32'h0);
      rd(cnt_adr(1), 32'h0, "per_cnt0");

      // channel 2: FORCE, hw set vs W1C, load vs expiry
      wr(OFF_ENABLE, 32'h4, "en4");
      wr(OFF_FORCE, 32'h4, "force4");
      rd(OFF_PENDING, 32'h4, "force_set");
      rd(OFF_FORCE, 32'h0, "force_reads0");
      wr(OFF_PENDING, 32'h4, "w1c4");
      rd(OFF_PENDING, 32'h0, "w1c4_done");
      wr(cnt_adr(2), 32'd2, "cnt2_2a");
      w = last_edge;
      wr(OFF_PENDING, 32'h4, "w1c_on_exp");
      chk("w1c_align", last_edge, w + 2);
      rd(OFF_PENDING, 32'h4, "hw_set_wins");
      wr(OFF_PENDING, 32'h4, "w1c4b");
      wr(cnt_adr(2), 32'd2, "cnt2_2b");
      w = last_edge;
      wr(cnt_adr(2), 32'd7, "cnt2_7");
      chk("load_align", last_edge, w + 2);
      rd(cnt_adr(2), 32'd6, "load_cnt6");
      rd(OFF_PENDING, 32'h0, "load_wins");
      wr(cnt_adr(2), 32'h0, "cnt2_stop");

      // errors, truncation, ignored address bits
      xfer(1'b0, 8'h30, 32'h0, v, resp);
      chk("err_resp", 32'(resp), 32'h1);
      chk("err_dat", v, 32'h0);
      @(negedge clk);
      chk("err_single", 32'({bus.wb_ack_o, bus.wb_err_o}), 32'h0);
      xfer(1'b1, 8'h30, 32'hFFFF_FFFF, v, resp);
      chk("err_wr_resp", 32'(resp), 32'h1);
      rd(OFF_ENABLE, 32'h4, "err_no_write");
      xfer(1'b0, 8'h14, 32'h0, v, resp);
      chk("gap_err", 32'(resp), 32'h1);
      wr(OFF_ENABLE, 32'hFFFF_FFFF, "en_wide");
      rd(OFF_ENABLE, 32'hF, "en_trunc");
      rd(8'h07, 32'hF, "adr_lsb_ignored");
      wr(cnt_adr(3), 32'h0001_2345, "cnt3_wide");
      w = last_edge;
      xfer(1'b0, cnt_adr(3), 32'h0, v, resp);
      chk("cnt_trunc", v, 32'h2345 - 32'(last_edge - w - 1));
      wr(cnt_adr(3), 32'h0, "cnt3_stop");

`ifdef WB_INTGEN_MULTI_PRESCALER_EN
      wr(OFF_PENDING, 32'hF, "pre_clr");
      wr(OFF_PRESCALE, 32'h1, "pre_1");
      w = last_edge;
      wr(cnt_adr(0), 32'd2, "pre_cnt");
      chk("pre_align", last_edge, w + 2);
      w = last_edge;
      wait_irq(0, e1);
      chk("pre_edge", e1, w + 4);
      rd(OFF_PRESCALE, 32'h1, "pre_read");
      wr(OFF_PRESCALE, 32'h0, "pre_0");
`else
      xfer(1'b1, OFF_PRESCALE, 32'h1, v, resp);
      chk("pre_absent", 32'(resp), 32'h1);
`endif

      // reset mid-access with a counter running
      wr(OFF_MODE, 32'h2, "rs_mode");
      wr(cnt_adr(1), 32'd10, "rs_cnt");
      wr(OFF_FORCE, 32'hF, "rs_force");
      chk("rs_pre_irq", 32'(irq_any), 32'h1);
      rst          = 1'b1;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      bus.wb_we_i  = 1'b0;
      bus.wb_adr_i = OFF_PENDING;
      repeat (2) begin
         @(negedge clk);
         chk("rs_no_ack", 32'({bus.wb_ack_o, bus.wb_err_o}), 32'h0);
      end
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      rst          = 1'b0;
      chk("rs_irq", 32'({irq_any, irq}), 32'h0);
      chk("rs_dat", bus.wb_dat_o, 32'h0);
      rd(OFF_PENDING, 32'h0, "rs_pend");
      rd(OFF_ENABLE, 32'h0, "rs_en");
      rd(OFF_MODE, 32'h0, "rs_mode_rd");
      rd(cnt_adr(1), 32'h0, "rs_cnt_rd");
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         seen |= irq_any;
      end
      chk("rs_quiet", 32'(seen), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
